jelly3_mat_to_axi4s: RTL and testbench
======================================

Name: jelly3_mat_to_axi4s

Overview:
Converts a raster image stream on the mat signal set (row_first/row_last/col_first/col_last/de/user/data/valid, advanced by a clock enable) into AXI4-Stream video (tuser[0] = frame start, tlast = line end).
The mat side cannot be back-pressured, so an internal FIFO absorbs AXI4-Stream stalls.
On overflow the block drops pixels and resynchronises at the next frame start.
It sits at the sink end of a mat processing pipeline and feeds VDMA/stream consumers.

Parameters:
DATA_BITS, 24, pixel data width (s_mat_data, m_axi4s_tdata)
USER_BITS, 1, user width; bit 0 of m_axi4s_tuser carries frame start, mat user is placed in bits above it
FIFO_PTR_BITS, 6, FIFO depth = 2**FIFO_PTR_BITS entries
COUNT_BITS, 16, width of the frame and drop counters

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
cke  input  1  mat-side clock enable; mat inputs are sampled only when high
s_mat_row_first  input  1  first row of frame
s_mat_row_last  input  1  last row of frame
s_mat_col_first  input  1  first column of row
s_mat_col_last  input  1  last column of row
s_mat_de  input  1  pixel is active image data
s_mat_user  input  USER_BITS  per-pixel user bits
s_mat_data  input  DATA_BITS  pixel data
s_mat_valid  input  1  mat slot valid
m_axi4s_tuser  output  USER_BITS+1  bit0 = frame start, bits above = mat user
m_axi4s_tlast  output  1  end of line
m_axi4s_tdata  output  DATA_BITS  pixel
m_axi4s_tvalid  output  1  AXI4-Stream valid
m_axi4s_tready  input  1  AXI4-Stream ready
clear  input  1  clears the sticky overflow flag and both counters
overflow  output  1  sticky: set when at least one pixel was dropped
frame_count  output  COUNT_BITS  frames accepted (counted at frame start); wraps
drop_count  output  COUNT_BITS  pixels dropped; saturates at all-ones

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - FIFO flushed; state=WAIT.
  - m_axi4s_tvalid=0, tuser=0, tlast=0, tdata=0.
  - overflow=0; frame_count=0; drop_count=0.
- Pixel event: cke & s_mat_valid & s_mat_de. No pixel events occur when cke=0; all state is held.
- Frame start (fs) = pixel event with row_first & col_first.
- FIFO entry = {user, fs, col_last, data}.
- State machine:
  - WAIT: discard all pixel events without counting them as drops. On fs, go to RUN and push the pixel (fs-when-full is handled below).
  - RUN: push every pixel event. If a pixel event occurs while the FIFO is full, drop that pixel, set overflow, drop_count+1, and go to DROP.
  - DROP: discard pixel events, each counting drop_count+1. On fs with the FIFO not full, push the pixel and go to RUN. On fs with the FIFO full, drop the pixel, count it, and stay in DROP.
- frame_count increments on every pushed fs.
- Full test uses the registered count. A pop and a push in the same cycle while full is still a drop; no combinational ready-through.
- Output:
  - The FIFO is first-word-fall-through with a registered output stage.
  - A pixel pushed in cycle N appears with m_axi4s_tvalid=1 in cycle N+1 when the FIFO was empty.
  - Transfer occurs on tvalid & tready.
  - tdata, tuser and tlast are stable while tvalid=1 and tready=0.
  - The output is independent of cke; the stream drains even when cke=0.
- Entries already queued before an overflow drain unchanged. The truncated frame therefore has no final tlast; downstream resynchronises on tuser[0].
- clear: takes effect next cycle. If clear and a drop happen in the same cycle, clear wins for overflow, and drop_count is loaded with 1.
- Count register width is FIFO_PTR_BITS+1. Empty = count 0; full = count 2**FIFO_PTR_BITS. Pointers wrap modulo the depth.

Decomposition:
- Package jelly3_mat_to_axi4s_pkg: state enum (WAIT, RUN, DROP) and the FIFO entry struct, parameterised via the module's typedefs.
- Sub-module jelly3_mat_to_axi4s_fifo: synchronous FWFT FIFO.
  - Push: s_valid; full flag.
  - Pop: m_valid / m_ready with a registered output slot.
  - Synchronous active-low reset.

Test Plan:
- 4x3 frame, cke=1, tready=1:
  - 12 beats out.
  - tuser[0]=1 only on beat 0; tlast on beats 3, 7, 11.
  - First tvalid one cycle after the first pixel event.
  - frame_count=1.
- Same frame with tready toggling 1/0 every cycle and depth 64: all 12 beats delivered in order, no drop, overflow=0.
- FIFO_PTR_BITS=2, tready=0, 8x2 frame:
  - First 4 pixels queued; pixel 5 dropped; overflow=1; drop_count=12.
  - After tready=1, exactly 4 beats, the last with tlast=0.
  - Next frame passes intact with tuser[0] on its first beat.
- Stream begins mid-frame at row 2: nothing output until the next fs; drop_count stays 0.
- cke low for 5 cycles mid-line with the mat inputs changing: no pushes; output continues to drain; data order is unchanged after cke returns.
- aresetn=0 for one cycle mid-frame with 3 entries queued:
  - Next cycle tvalid=0; counters are 0.
  - Remaining pixels of that frame are ignored until the next fs.
  - Then clear pulsed together with a drop: overflow=0, drop_count=1.

Source files
------------

// File: rtl/jelly3_mat_to_axi4s_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jelly3_mat_to_axi4s_pkg : shared types for the mat -> AXI4-Stream bridge
// Revision : 1.0
// ---------------------------------------------------------------------------
package jelly3_mat_to_axi4s_pkg;

  localparam int c_STATE_BITS = 2;

  // WAIT: hunting for a frame start, RUN: forwarding, DROP: overflowed
  typedef enum logic [c_STATE_BITS-1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/jelly3_mat_to_axi4s_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jelly3_mat_to_axi4s_fifo : first-word-fall-through FIFO, registered output
// Revision : 1.0
// ---------------------------------------------------------------------------
module jelly3_mat_to_axi4s_fifo #(
  parameter int WIDTH    = 27,
  parameter int PTR_BITS = 6
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_full,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_valid,
  input  logic             i_m_ready
);

  localparam int                DEPTH        = 1 << PTR_BITS;
  localparam logic [PTR_BITS:0] c_FULL_COUNT = {1'b1, {PTR_BITS{1'b0}}};

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [PTR_BITS:0]   r_count;
  logic [WIDTH-1:0]    r_m_data;
  logic                r_m_valid;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_slot_free;
  logic w_mem_empty;
  logic w_bypass;
  logic w_mem_wr;
  logic w_mem_rd;

  // r_count covers RAM plus the output slot, so the slot is part of capacity.
  // The slot is always filled while RAM holds data, so RAM never exceeds
  // DEPTH-1 entries and pointer equality alone means RAM empty.
  assign w_full      = (r_count == c_FULL_COUNT);
  assign w_push      = i_s_valid & ~w_full;
  assign w_pop       = r_m_valid & i_m_ready;
  assign w_slot_free = ~r_m_valid | i_m_ready;
  assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
  assign w_bypass    = w_push & w_slot_free & w_mem_empty;
  assign w_mem_wr    = w_push & ~w_bypass;
  assign w_mem_rd    = w_slot_free & ~w_mem_empty;

  always_ff @(posedge aclk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= i_s_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      end
      if (w_mem_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      end
      r_count <= r_count + (PTR_BITS+1)'(w_push) - (PTR_BITS+1)'(w_pop);
      if (w_slot_free) begin
        if (w_mem_rd) begin
          r_m_data  <= r_mem[r_rd_ptr];
          r_m_valid <= 1'b1;
        end else if (w_bypass) begin
          r_m_data  <= i_s_data;
          r_m_valid <= 1'b1;
        end else begin
          r_m_valid <= 1'b0;
        end
      end
    end
  end

  assign o_s_full  = w_full;
  assign o_m_data  = r_m_data;
  assign o_m_valid = r_m_valid;

endmodule
`default_nettype wire

// File: rtl/jelly3_mat_to_axi4s.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jelly3_mat_to_axi4s : mat raster stream to AXI4-Stream video with overflow drop
// Revision : 1.0
// ---------------------------------------------------------------------------
module jelly3_mat_to_axi4s
  import jelly3_mat_to_axi4s_pkg::*;
#(
  parameter int DATA_BITS     = 24,
  parameter int USER_BITS     = 1,
  parameter int FIFO_PTR_BITS = 6,
  parameter int COUNT_BITS    = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cke,

  input  logic                  s_mat_row_first,
  input  logic                  s_mat_row_last,
  input  logic                  s_mat_col_first,
  input  logic                  s_mat_col_last,
  input  logic                  s_mat_de,
  input  logic [USER_BITS-1:0]  s_mat_user,
  input  logic [DATA_BITS-1:0]  s_mat_data,
  input  logic                  s_mat_valid,

  output logic [USER_BITS:0]    m_axi4s_tuser,
  output logic                  m_axi4s_tlast,
  output logic [DATA_BITS-1:0]  m_axi4s_tdata,
  output logic                  m_axi4s_tvalid,
  input  logic                  m_axi4s_tready,

  input  logic                  clear,
  output logic                  overflow,
  output logic [COUNT_BITS-1:0] frame_count,
  output logic [COUNT_BITS-1:0] drop_count
);

  typedef struct packed {
    logic [USER_BITS-1:0] user;
    logic                 fs;
    logic                 last;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  state_t                r_state;
  logic                  r_overflow;
  logic [COUNT_BITS-1:0] r_frame_count;
  logic [COUNT_BITS-1:0] r_drop_count;

  logic   w_pix;
  logic   w_fs;
  logic   w_full;
  logic   w_push;
  logic   w_drop;
  logic   w_out_valid;
  entry_t w_in;
  entry_t w_out;

  assign w_pix = cke & s_mat_valid & s_mat_de;
  assign w_fs  = w_pix & s_mat_row_first & s_mat_col_first;

  assign w_in.user = s_mat_user;
  assign w_in.fs   = w_fs;
  assign w_in.last = s_mat_col_last;
  assign w_in.data = s_mat_data;

  always_comb begin
    w_push = 1'b0;
    w_drop = 1'b0;
    if (w_pix) begin
      case (r_state)
        ST_WAIT: begin
          if (w_fs) begin
            w_push = ~w_full;
            w_drop = w_full;
          end
        end
        ST_RUN: begin
          w_push = ~w_full;
          w_drop = w_full;
        end
        ST_DROP: begin
          w_push = w_fs & ~w_full;
          w_drop = ~(w_fs & ~w_full);
        end
        default: begin
          w_push = 1'b0;
          w_drop = 1'b0;
        end
      endcase
    end
  end

  // Clear has priority over a simultaneous event; that event then seeds the count.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= ST_WAIT;
      r_overflow    <= 1'b0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_drop) begin
        r_state <= ST_DROP;
      end else if (w_push) begin
        r_state <= ST_RUN;
      end

      if (clear) begin
        r_overflow    <= 1'b0;
        r_drop_count  <= COUNT_BITS'(w_drop);
        r_frame_count <= COUNT_BITS'(w_push & w_fs);
      end else begin
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (~&r_drop_count) begin
            r_drop_count <= r_drop_count + COUNT_BITS'(1);
          end
        end
        if (w_push && w_fs) begin
          r_frame_count <= r_frame_count + COUNT_BITS'(1);
        end
      end
    end
  end

  jelly3_mat_to_axi4s_fifo #(
    .WIDTH    ($bits(entry_t)),
    .PTR_BITS (FIFO_PTR_BITS)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_s_data  (w_in),
    .i_s_valid (w_push),
    .o_s_full  (w_full),
    .o_m_data  (w_out),
    .o_m_valid (w_out_valid),
    .i_m_ready (m_axi4s_tready)
  );

  assign m_axi4s_tuser  = {w_out.user, w_out.fs};
  assign m_axi4s_tlast  = w_out.last;
  assign m_axi4s_tdata  = w_out.data;
  assign m_axi4s_tvalid = w_out_valid;

  assign overflow    = r_overflow;
  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_jelly3_mat_to_axi4s.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jelly3_mat_to_axi4s : directed scoreboard bench for jelly3_mat_to_axi4s
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_jelly3_mat_to_axi4s;

  localparam int DATA_BITS     = 24;
  localparam int USER_BITS     = 1;
  localparam int FIFO_PTR_BITS = 3;
  localparam int COUNT_BITS    = 16;

  typedef logic [USER_BITS+DATA_BITS+1:0] beat_t;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic                  cke;
  logic                  s_mat_row_first;
  logic                  s_mat_row_last;
  logic                  s_mat_col_first;
  logic                  s_mat_col_last;
  logic                  s_mat_de;
  logic [USER_BITS-1:0]  s_mat_user;
  logic [DATA_BITS-1:0]  s_mat_data;
  logic                  s_mat_valid;
  logic [USER_BITS:0]    m_axi4s_tuser;
  logic                  m_axi4s_tlast;
  logic [DATA_BITS-1:0]  m_axi4s_tdata;
  logic                  m_axi4s_tvalid;
  logic                  m_axi4s_tready;
  logic                  clear;
  logic                  overflow;
  logic [COUNT_BITS-1:0] frame_count;
  logic [COUNT_BITS-1:0] drop_count;

  logic tready_set;
  logic tog_mode;
  logic r_tog = 1'b0;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    beats  = 0;
  int    b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) r_tog <= ~r_tog;
  assign m_axi4s_tready = tog_mode ? r_tog : tready_set;

  jelly3_mat_to_axi4s #(
    .DATA_BITS     (DATA_BITS),
    .USER_BITS     (USER_BITS),
    .FIFO_PTR_BITS (FIFO_PTR_BITS),
    .COUNT_BITS    (COUNT_BITS)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .cke             (cke),
    .s_mat_row_first (s_mat_row_first),
    .s_mat_row_last  (s_mat_row_last),
    .s_mat_col_first (s_mat_col_first),
    .s_mat_col_last  (s_mat_col_last),
    .s_mat_de        (s_mat_de),
    .s_mat_user      (s_mat_user),
    .s_mat_data      (s_mat_data),
    .s_mat_valid     (s_mat_valid),
    .m_axi4s_tuser   (m_axi4s_tuser),
    .m_axi4s_tlast   (m_axi4s_tlast),
    .m_axi4s_tdata   (m_axi4s_tdata),
    .m_axi4s_tvalid  (m_axi4s_tvalid),
    .m_axi4s_tready  (m_axi4s_tready),
    .clear           (clear),
    .overflow        (overflow),
    .frame_count     (frame_count),
    .drop_count      (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output side: every accepted beat must match the oldest expected entry.
  always @(negedge aclk) begin
    beat_t e;
    if (aresetn === 1'b1 && m_axi4s_tvalid === 1'b1 && m_axi4s_tready === 1'b1) begin
      beats++;
      if (sb.size() == 0) begin
        chk("unexpected_beat", {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("beat", {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, e);
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_mat_valid = 1'b0;
    cke         = 1'b1;
    repeat (n) step();
  endtask

  task automatic pix(input logic c, input logic rf, input logic rl, input logic cf,
                     input logic cl, input logic [DATA_BITS-1:0] d,
                     input logic [USER_BITS-1:0] u, input logic clr, input bit exp_push);
    cke             = c;
    s_mat_valid     = 1'b1;
    s_mat_de        = 1'b1;
    s_mat_row_first = rf;
    s_mat_row_last  = rl;
    s_mat_col_first = cf;
    s_mat_col_last  = cl;
    s_mat_data      = d;
    s_mat_user      = u;
    clear           = clr;
    if (exp_push) sb.push_back({u, rf & cf, cl, d});
    step();
    clear = 1'b0;
  endtask

  // Drives raster indices first..last of a w x h frame; the first npush are expected queued.
  task automatic frame(input int w, input int h, input int first, input int last,
                       input int base, input int npush, input int clr_idx, input bit chk_first);
    int r;
    int c;
    for (int i = first; i <= last; i++) begin
      r = i / w;
      c = i % w;
      pix(1'b1, r == 0, r == h - 1, c == 0, c == w - 1, DATA_BITS'(base + i),
          USER_BITS'(i), i == clr_idx, (i - first) < npush);
      if (chk_first && i == first) chk("first_tvalid", m_axi4s_tvalid, 1);
    end
    s_mat_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0 && m_axi4s_tvalid !== 1'b1) break;
      step();
    end
    chk("drain_queue", sb.size(), 0);
    chk("drain_tvalid", m_axi4s_tvalid, 0);
  endtask

  task automatic do_reset(input int n);
    aresetn = 1'b0;
    sb.delete();
    repeat (n) step();
    aresetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cke = 1'b1; s_mat_valid = 1'b0; s_mat_de = 1'b0;
    s_mat_row_first = 1'b0; s_mat_row_last = 1'b0;
    s_mat_col_first = 1'b0; s_mat_col_last = 1'b0;
    s_mat_user = '0; s_mat_data = '0; clear = 1'b0;
    tready_set = 1'b1; tog_mode = 1'b0; aresetn = 1'b0;

    // reset state
    do_reset(3);
    chk("rst_tvalid", m_axi4s_tvalid, 0);
    chk("rst_tuser", m_axi4s_tuser, 0);
    chk("rst_tlast", m_axi4s_tlast, 0);
    chk("rst_tdata", m_axi4s_tdata, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_drop_count", drop_count, 0);

    // 4x3 frame, full-rate ready
    b0 = beats;
    chk("pre_tvalid", m_axi4s_tvalid, 0);
    frame(4, 3, 0, 11, 'h100, 12, -1, 1'b1);
    wait_drain();
    chk("f1_beats", beats - b0, 12);
    chk("f1_frame_count", frame_count, 1);
    chk("f1_overflow", overflow, 0);

    // same frame with ready toggling
    b0 = beats;
    tog_mode = 1'b1;
    frame(4, 3, 0, 11, 'h200, 12, -1, 1'b0);
    wait_drain();
    tog_mode = 1'b0;
    chk("tog_beats", beats - b0, 12);
    chk("tog_overflow", overflow, 0);
    chk("tog_drop_count", drop_count, 0);
    chk("tog_frame_count", frame_count, 2);

    // overflow: 16x2 frame into a depth-8 FIFO with ready low
    tready_set = 1'b0;
    b0 = beats;
    frame(16, 2, 0, 31, 'h300, 8, -1, 1'b0);
    idle(3);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop_count", drop_count, 24);
    chk("ovf_frame_count", frame_count, 3);
    chk("ovf_stall_tvalid", m_axi4s_tvalid, 1);
    chk("ovf_stall_tdata", m_axi4s_tdata, 'h300);
    chk("ovf_stall_tuser", m_axi4s_tuser, 1);
    tready_set = 1'b1;
    wait_drain();
    chk("ovf_beats", beats - b0, 8);
    b0 = beats;
    frame(4, 2, 0, 7, 'h400, 8, -1, 1'b0);
    wait_drain();
    chk("resync_beats", beats - b0, 8);
    chk("resync_frame_count", frame_count, 4);
    chk("resync_drop_count", drop_count, 24);

    // stream begins mid-frame at row 2
    do_reset(1);
    b0 = beats;
    frame(4, 4, 8, 15, 'h500, 0, -1, 1'b0);
    idle(5);
    chk("mid_beats", beats - b0, 0);
    chk("mid_tvalid", m_axi4s_tvalid, 0);
    chk("mid_drop_count", drop_count, 0);
    frame(4, 2, 0, 7, 'h600, 8, -1, 1'b0);
    wait_drain();
    chk("mid_next_beats", beats - b0, 8);
    chk("mid_frame_count", frame_count, 1);

    // cke low mid-line with inputs moving
    b0 = beats;
    frame(4, 2, 0, 1, 'h700, 2, -1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      pix(1'b0, 1'b1, k[0], 1'b1, k[1], DATA_BITS'($urandom), USER_BITS'(k), 1'b0, 1'b0);
    end
    chk("cke_drained_queue", sb.size(), 0);
    chk("cke_drained_tvalid", m_axi4s_tvalid, 0);
    frame(4, 2, 2, 7, 'h700, 6, -1, 1'b0);
    wait_drain();
    chk("cke_beats", beats - b0, 8);
    chk("cke_frame_count", frame_count, 2);
    chk("cke_drop_count", drop_count, 0);

    // reset mid-frame with 3 queued
    tready_set = 1'b0;
    frame(4, 2, 0, 2, 'h800, 3, -1, 1'b0);
    chk("rq_tvalid_before", m_axi4s_tvalid, 1);
    do_reset(1);
    chk("rq_tvalid", m_axi4s_tvalid, 0);
    chk("rq_frame_count", frame_count, 0);
    chk("rq_drop_count", drop_count, 0);
    chk("rq_overflow", overflow, 0);
    tready_set = 1'b1;
    b0 = beats;
    frame(4, 2, 3, 7, 'h800, 0, -1, 1'b0);
    idle(5);
    chk("rq_ignored_beats", beats - b0, 0);

    // clear together with a drop
    tready_set = 1'b0;
    frame(16, 1, 0, 15, 'h900, 8, 15, 1'b0);
    chk("clr_overflow", overflow, 0);
    chk("clr_drop_count", drop_count, 1);
    chk("clr_frame_count", frame_count, 0);
    tready_set = 1'b1;
    b0 = beats;
    wait_drain();
    chk("clr_beats", beats - b0, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
